// File: rtl/mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | mem_arbiter: round-robin fetch/data arbiter with BRAM/print/CLINT decode  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_arbiter #(
  parameter logic [31:0] bram_base_addr  = 32'h0000_0000,
  parameter logic [31:0] bram_top_addr   = 32'h0010_0000,
  parameter logic [31:0] print_base_addr = 32'h0100_0000,
  parameter logic [31:0] print_top_addr  = 32'h0100_0004,
  parameter logic [31:0] clint_base_addr = 32'h0200_0000,
  parameter logic [31:0] clint_top_addr  = 32'h0200_C000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        imem_valid,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  output logic        imem_error,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  output logic        dmem_error,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        bram_valid,
  output logic        print_valid,
  output logic        clint_valid,
  input  logic [31:0] bram_rdata,
  input  logic [31:0] print_rdata,
  input  logic [31:0] clint_rdata,
  input  logic        bram_ready,
  input  logic        print_ready,
  input  logic        clint_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        last_instr;
  logic        any_valid;
  logic        grant_instr;
  logic [31:0] grant_addr;
  logic        hit_bram;
  logic        hit_print;
  logic        hit_clint;
  logic        hit_any;
  logic        sel_ready;
  logic [31:0] sel_rdata;

  // Window test as (addr - base) < size: one unsigned compare, wraps below base.
  always_comb begin
    any_valid   = imem_valid | dmem_valid;
    grant_instr = imem_valid & (~dmem_valid | ~last_instr);
    grant_addr  = grant_instr ? imem_addr : dmem_addr;
    hit_bram    = (grant_addr - bram_base_addr) < (bram_top_addr - bram_base_addr);
    hit_print   = !hit_bram &&
                  ((grant_addr - print_base_addr) < (print_top_addr - print_base_addr));
    hit_clint   = !hit_bram && !hit_print &&
                  ((grant_addr - clint_base_addr) < (clint_top_addr - clint_base_addr));
    hit_any     = hit_bram | hit_print | hit_clint;
  end

  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = 32'h0;
    if (bram_valid) begin
      sel_ready = bram_ready;
      sel_rdata = bram_rdata;
    end else if (print_valid) begin
      sel_ready = print_ready;
      sel_rdata = print_rdata;
    end else if (clint_valid) begin
      sel_ready = clint_ready;
      sel_rdata = clint_rdata;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_next = hit_any ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (sel_ready) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_instr  <= 1'b1;
      mem_instr   <= 1'b0;
      mem_addr    <= 32'h0;
      mem_wdata   <= 32'h0;
      mem_wstrb   <= 4'h0;
      bram_valid  <= 1'b0;
      print_valid <= 1'b0;
      clint_valid <= 1'b0;
      imem_ready  <= 1'b0;
      imem_rdata  <= 32'h0;
      imem_error  <= 1'b0;
      dmem_ready  <= 1'b0;
      dmem_rdata  <= 32'h0;
      dmem_error  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            last_instr  <= grant_instr;
            mem_instr   <= grant_instr;
            mem_addr    <= grant_addr;
            mem_wdata   <= grant_instr ? 32'h0 : dmem_wdata;
            mem_wstrb   <= grant_instr ? 4'h0 : dmem_wstrb;
            bram_valid  <= hit_bram;
            print_valid <= hit_print;
            clint_valid <= hit_clint;
            // Unmapped: answer directly with error and zero data.
            if (!hit_any) begin
              imem_ready <= grant_instr;
              imem_error <= grant_instr;
              imem_rdata <= 32'h0;
              dmem_ready <= !grant_instr;
              dmem_error <= !grant_instr;
              dmem_rdata <= 32'h0;
            end
          end
        end
        WAIT: begin
          if (sel_ready) begin
            bram_valid  <= 1'b0;
            print_valid <= 1'b0;
            clint_valid <= 1'b0;
            imem_ready  <= mem_instr;
            imem_error  <= 1'b0;
            imem_rdata  <= mem_instr ? sel_rdata : 32'h0;
            dmem_ready  <= !mem_instr;
            dmem_error  <= 1'b0;
            dmem_rdata  <= mem_instr ? 32'h0 : sel_rdata;
          end
        end
        default: begin
          imem_ready <= 1'b0;
          imem_rdata <= 32'h0;
          imem_error <= 1'b0;
          dmem_ready <= 1'b0;
          dmem_rdata <= 32'h0;
          dmem_error <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter and address decoder between the core's instruction-fetch port and data port and the three system slaves: BRAM, print and CLINT. It grants one request at a time with round-robin fairness, routes the request to the slave that owns the address, and returns the response to the granted requester. It sits between the core (behind the fetch buffer and store buffer) and the slave blocks.

## Interface
- bram_base_addr, 32'h000000: BRAM window base (inclusive).
- bram_top_addr, 32'h100000: BRAM window top (exclusive).
- print_base_addr, 32'h1000000: print window base.
- print_top_addr, 32'h1000004: print window top.
- clint_base_addr, 32'h2000000: CLINT window base.
- clint_top_addr, 32'h200C000: CLINT window top.
- reset  in  1  synchronous, active-low reset.
- clock  in  1  single clock; all state updates on the rising edge.
- imem_valid  in  1  fetch request; held with stable address until imem_ready.
- imem_addr  in  32  fetch address.
- imem_rdata  out  32  fetch data; valid while imem_ready=1.
- imem_ready  out  1  one-cycle response strobe.
- imem_error  out  1  unmapped address; valid with imem_ready.
- dmem_valid  in  1  data request; held with stable payload until dmem_ready.
- dmem_addr  in  32  data address.
- dmem_wdata  in  32  store data.
- dmem_wstrb  in  4  byte strobes; 0 means load.
- dmem_rdata  out  32  load data.
- dmem_ready  out  1  one-cycle response strobe.
- dmem_error  out  1  unmapped address.
- mem_instr  out  1  1 when the current downstream access is a fetch.
- mem_addr  out  32  downstream address.
- mem_wdata  out  32  downstream store data.
- mem_wstrb  out  4  downstream strobes; forced to 0 for fetches.
- bram_valid / print_valid / clint_valid  out  1 each  per-slave request.
- bram_rdata / print_rdata / clint_rdata  in  32 each  per-slave read data.
- bram_ready / print_ready / clint_ready  in  1 each  per-slave completion.

## Operation
- States: IDLE, WAIT, RESP.
- **IDLE**
  - If no request is valid, stay in IDLE.
  - If exactly one request is valid, grant it.
  - If both are valid, grant the requester not granted last. The last-grant pointer resets to "instruction", so the data port wins the first tie.
  - On grant:
    - Register mem_addr, mem_wdata, mem_wstrb (0 for fetch) and mem_instr.
    - Decode the address, checking the windows in the order bram, print, clint, each as base <= addr < top.
    - Set the matching slave valid and go to WAIT.
    - If no window matches, set no slave valid, set err=1 and go to RESP.
    - Update the last-grant pointer.
- **WAIT**
  - Hold the slave valid and the mem_* outputs until the selected slave's ready=1.
  - On that cycle, capture that slave's rdata, clear the slave valid and go to RESP.
  - Ready and rdata from unselected slaves are ignored.
- **RESP**
  - Drive the granted port's ready=1 with the captured rdata and error for exactly one cycle.
  - The other port's ready stays 0.
  - Return to IDLE.
- Unmapped access: rdata=0, error=1, and no write reaches any slave.
- Requester rule: valid drops, or presents a new request, on the cycle after ready. The arbiter does not sample requests in RESP, so a held valid is never granted twice.
- The arbiter never aborts an access. A slave that never asserts ready stalls the arbiter indefinitely (by design).
- Reset, including mid-operation:
  - All outputs go to 0 and the state goes to IDLE.
  - The last-grant pointer is set to "instruction".
  - The in-flight access is dropped and no ready is issued for it.

## Timing
- Grant edge: cycle 0 is the cycle in which valid is sampled in IDLE. The slave valid and mem_* outputs appear in cycle 1.
- Slave completion: if the slave asserts ready in cycle k (k >= 1), the requester's ready is high in cycle k+1.
  - Minimum mapped latency is 2 cycles (ready in cycle 1, response in cycle 2).
- Unmapped latency: the response is in cycle 1.
- Back-to-back throughput: IDLE follows RESP, so the next grant occurs at cycle k+2. Each mapped access therefore occupies at least 3 cycles.
- Slave valids are mutually exclusive and are never high in RESP or IDLE.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Single BRAM load:
  - Stimulus: dmem_valid with addr=0x100, wstrb=0; bram_ready in cycle 1 with rdata=0xDEADBEEF.
  - Required: bram_valid high in cycle 1 only; dmem_ready=1 in cycle 2 with rdata=0xDEADBEEF, error=0.
- Contention:
  - Stimulus: imem and dmem both valid from reset, BRAM ready after 1 cycle.
  - Required: grants alternate data, instr, data, instr; each ready arrives 3 cycles apart; mem_instr matches the granted port; mem_wstrb=0 on fetches.
- Decode boundaries:
  - Addresses: 0x0FFFFC → bram; 0x100000 → unmapped (error=1, rdata=0, no slave valid, response in cycle 1); 0x1000000 → print; 0x1000004 → unmapped; 0x200BFFC → clint.
- Print store with slow slave:
  - Stimulus: dmem write to 0x1000000, wdata=0x41, wstrb=0xF; print_ready after 5 cycles; bram_ready pulsed meanwhile.
  - Required: the stray bram_ready is ignored; print_valid is held stable for 5 cycles; dmem_ready arrives one cycle after print_ready.
- Reset mid-access:
  - Stimulus: assert reset=0 while in WAIT.
  - Required: all outputs 0 on the next cycle; no ready is issued for the dropped access; the data port wins the first tie after reset.
- Held valid:
  - Stimulus: requester keeps valid high one extra cycle after ready (with a new address).
  - Required: exactly one new grant, with no duplicate response for the old request.
